// File: rtl/ip_tx_arbiter_if.sv
// Signal bundle around ip_tx_arbiter: per-requester config, length and payload streams,
// the shared header generator's config/length/header streams, and the packet output.
interface ip_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [31:0]              src_ip;
    logic [NUM_REQ-1:0][7:0]  req_protocol;
    logic [NUM_REQ-1:0][31:0] req_dest_ip;

    logic [NUM_REQ-1:0]       req_len_tvalid;
    logic [NUM_REQ-1:0]       req_len_tready;
    logic [NUM_REQ-1:0][15:0] req_len_tdata;

    logic [NUM_REQ-1:0]       pay_i_tvalid;
    logic [NUM_REQ-1:0]       pay_i_tready;
    logic [NUM_REQ-1:0]       pay_i_tlast;
    logic [NUM_REQ-1:0][7:0]  pay_i_tdata;

    logic [7:0]               hg_protocol;
    logic [31:0]              hg_src_ip;
    logic [31:0]              hg_dest_ip;
    logic                     hg_len_tvalid;
    logic                     hg_len_tready;
    logic                     hg_len_tlast;
    logic [15:0]              hg_len_tdata;

    logic                     hdr_i_tvalid;
    logic                     hdr_i_tready;
    logic                     hdr_i_tlast;
    logic [7:0]               hdr_i_tdata;

    logic                     axis_o_tvalid;
    logic                     axis_o_tready;
    logic                     axis_o_tlast;
    logic [7:0]               axis_o_tdata;

    logic [REQ_W-1:0]         grant;

    // Arbiter side
    modport master (
        input  src_ip, req_protocol, req_dest_ip,
        input  req_len_tvalid, req_len_tdata,
        output req_len_tready,
        input  pay_i_tvalid, pay_i_tlast, pay_i_tdata,
        output pay_i_tready,
        output hg_protocol, hg_src_ip, hg_dest_ip,
        output hg_len_tvalid, hg_len_tlast, hg_len_tdata,
        input  hg_len_tready,
        input  hdr_i_tvalid, hdr_i_tlast, hdr_i_tdata,
        output hdr_i_tready,
        output axis_o_tvalid, axis_o_tlast, axis_o_tdata,
        input  axis_o_tready,
        output grant
    );

    // Environment side (sources, header generator, framing stage)
    modport slave (
        output src_ip, req_protocol, req_dest_ip,
        output req_len_tvalid, req_len_tdata,
        input  req_len_tready,
        output pay_i_tvalid, pay_i_tlast, pay_i_tdata,
        input  pay_i_tready,
        input  hg_protocol, hg_src_ip, hg_dest_ip,
        input  hg_len_tvalid, hg_len_tlast, hg_len_tdata,
        output hg_len_tready,
        output hdr_i_tvalid, hdr_i_tlast, hdr_i_tdata,
        input  hdr_i_tready,
        input  axis_o_tvalid, axis_o_tlast, axis_o_tdata,
        output axis_o_tready,
        input  grant
    );
endinterface

// File: rtl/ip_tx_arbiter.sv
// Round-robin arbiter sharing one IPv4 header generator between NUM_REQ sources;
// emits generated header then the granted source's payload as one byte stream.

// Per-requester ready steering: only the granted lane sees the downstream ready.
module ip_tx_arb_lane (
    input  logic sel,
    input  logic len_phase,
    input  logic pay_phase,
    input  logic hg_len_tready,
    input  logic axis_o_tready,
    output logic req_len_tready,
    output logic pay_i_tready
);
    assign req_len_tready = sel & len_phase & hg_len_tready;
    assign pay_i_tready   = sel & pay_phase & axis_o_tready;
endmodule

module ip_tx_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic            clk,
    input  logic            sresetn,
    ip_tx_arbiter_if.master bus
);
    localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LEN, HDR, PAY} state_t;

    state_t             state, state_nxt;
    logic [REQ_W-1:0]   rr_ptr, grant, sel_idx;
    logic               sel_vld, ld_grant, ld_zero, ret_idle, zero_len;
    logic [7:0]         hg_protocol;
    logic [31:0]        hg_src_ip, hg_dest_ip;
    logic               len_phase, pay_phase;
    logic               hg_rdy, out_rdy;
    logic [NUM_REQ-1:0] lane_sel, lane_len_rdy, lane_pay_rdy;

    // (base + off) mod NUM_REQ; off is always below NUM_REQ
    function automatic logic [REQ_W-1:0] wrap_add(input logic [REQ_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return sum[REQ_W-1:0];
    endfunction

    // Scan downward so the last hit is the closest one at or after rr_ptr.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_len_tvalid[wrap_add(rr_ptr, i)]) begin
                sel_vld = 1'b1;
                sel_idx = wrap_add(rr_ptr, i);
            end
        end
    end

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            hg_protocol <= '0;
            hg_src_ip   <= '0;
            hg_dest_ip  <= '0;
            zero_len    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ld_grant) begin
                grant       <= sel_idx;
                hg_protocol <= bus.req_protocol[sel_idx];
                hg_dest_ip  <= bus.req_dest_ip[sel_idx];
                hg_src_ip   <= bus.src_ip;
            end
            if (ld_zero)
                zero_len <= (bus.req_len_tdata[grant] == 16'd0);
            if (ret_idle)
                rr_ptr <= wrap_add(grant, 1);
        end
    end

    always_comb begin
        state_nxt         = state;
        ld_grant          = 1'b0;
        ld_zero           = 1'b0;
        ret_idle          = 1'b0;
        bus.hg_len_tvalid = 1'b0;
        bus.hg_len_tdata  = '0;
        bus.hg_len_tlast  = 1'b0;
        bus.hdr_i_tready  = 1'b0;
        bus.axis_o_tvalid = 1'b0;
        bus.axis_o_tdata  = '0;
        bus.axis_o_tlast  = 1'b0;
        case (state)
            IDLE: begin
                if (sel_vld) begin
                    ld_grant  = 1'b1;
                    state_nxt = LEN;
                end
            end
            LEN: begin
                bus.hg_len_tvalid = bus.req_len_tvalid[grant];
                bus.hg_len_tdata  = bus.req_len_tdata[grant];
                bus.hg_len_tlast  = 1'b1;
                if (bus.req_len_tvalid[grant] && bus.hg_len_tready) begin
                    ld_zero   = 1'b1;
                    state_nxt = HDR;
                end
            end
            HDR: begin
                bus.axis_o_tvalid = bus.hdr_i_tvalid;
                bus.axis_o_tdata  = bus.hdr_i_tdata;
                // A zero-length packet ends on the last header byte.
                bus.axis_o_tlast  = bus.hdr_i_tlast & zero_len;
                bus.hdr_i_tready  = bus.axis_o_tready;
                if (bus.hdr_i_tvalid && bus.axis_o_tready && bus.hdr_i_tlast) begin
                    if (zero_len) begin
                        state_nxt = IDLE;
                        ret_idle  = 1'b1;
                    end else begin
                        state_nxt = PAY;
                    end
                end
            end
            PAY: begin
                bus.axis_o_tvalid = bus.pay_i_tvalid[grant];
                bus.axis_o_tdata  = bus.pay_i_tdata[grant];
                bus.axis_o_tlast  = bus.pay_i_tlast[grant];
                if (bus.pay_i_tvalid[grant] && bus.axis_o_tready && bus.pay_i_tlast[grant]) begin
                    state_nxt = IDLE;
                    ret_idle  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign len_phase = (state == LEN);
    assign pay_phase = (state == PAY);
    assign hg_rdy    = bus.hg_len_tready;
    assign out_rdy   = bus.axis_o_tready;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_sel
        assign lane_sel[i] = (grant == REQ_W'(i));
    end

    ip_tx_arb_lane u_lane [NUM_REQ-1:0] (
        .sel            (lane_sel),
        .len_phase      (len_phase),
        .pay_phase      (pay_phase),
        .hg_len_tready  (hg_rdy),
        .axis_o_tready  (out_rdy),
        .req_len_tready (lane_len_rdy),
        .pay_i_tready   (lane_pay_rdy)
    );

    assign bus.req_len_tready = lane_len_rdy;
    assign bus.pay_i_tready   = lane_pay_rdy;
    assign bus.hg_protocol    = hg_protocol;
    assign bus.hg_src_ip      = hg_src_ip;
    assign bus.hg_dest_ip     = hg_dest_ip;
    assign bus.grant          = grant;
endmodule
